// File: rtl/id_ex_stage_buffer.sv
// ID/EX pipeline stage: 2-entry skid buffer with valid/ready handshake,
// synchronous flush, bubble-zeroed control field and saturating stall counter.
module id_ex_stage_buffer #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 14,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, nextState;

  logic [CTRL_W-1:0] mainCtrl, skidCtrl;
  logic [DATA_W-1:0] mainData, skidData;
  logic [CNT_W-1:0]  stallCnt;
  logic              accept, deliver;
  logic              loadMainIn, loadMainSkid, loadSkid;

  // Handshake outputs depend only on the state register.
  assign in_ready    = (state != FULL);
  assign out_valid   = (state != EMPTY);
  assign out_ctrl    = out_valid ? mainCtrl : '0;
  assign out_data    = mainData;
  assign stall_count = stallCnt;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      HALF:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    nextState    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    accept       = in_valid & in_ready & ~flush;
    deliver      = out_valid & out_ready;
    case (state)
      EMPTY: begin
        if (accept) begin
          loadMainIn = 1'b1;
          nextState  = HALF;
        end
      end
      HALF: begin
        if (accept && deliver) begin
          loadMainIn = 1'b1;
        end else if (accept) begin
          loadSkid  = 1'b1;
          nextState = FULL;
        end else if (deliver) begin
          nextState = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          loadMainSkid = 1'b1;
          nextState    = HALF;
        end
      end
      default: nextState = EMPTY;
    endcase
    // Flush empties the stage but must leave out_data on its current value.
    if (flush) begin
      nextState    = EMPTY;
      loadMainSkid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mainCtrl <= '0;
      mainData <= '0;
      skidCtrl <= '0;
      skidData <= '0;
    end else begin
      if (loadMainIn) begin
        mainCtrl <= in_ctrl;
        mainData <= in_data;
      end else if (loadMainSkid) begin
        mainCtrl <= skidCtrl;
        mainData <= skidData;
      end
      if (loadSkid) begin
        skidCtrl <= in_ctrl;
        skidData <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      stallCnt <= '0;
    else if (out_valid && !out_ready && (stallCnt != '1))
      stallCnt <= stallCnt + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// Self-checking bench for id_ex_stage_buffer: queue-based reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_id_ex_stage_buffer;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CTRL_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_count;

  logic              sInReady, sOutValid;
  logic [CTRL_W-1:0] sOutCtrl;
  logic [DATA_W-1:0] sOutData;
  logic [1:0]        sOcc;
  logic [3:0]        sStall;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .flush(flush), .occupancy(occupancy), .stall_count(stall_count)
  );

  id_ex_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sInReady),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(sOutValid),
    .out_ready(out_ready), .out_ctrl(sOutCtrl), .out_data(sOutData),
    .flush(flush), .occupancy(sOcc), .stall_count(sStall)
  );

  // Reference model: FIFO of held entries, capacity 2.
  logic [CTRL_W-1:0] qc[$];
  logic [DATA_W-1:0] qd[$];
  logic [DATA_W-1:0] lastData = '0;
  longint unsigned   stallEvents = 0;

  always @(posedge clk) begin
    if (!rst) begin
      qc.delete();
      qd.delete();
      lastData = '0;
      stallEvents = 0;
    end else begin
      bit mValid, mReady, acc, del;
      mValid = (qd.size() > 0);
      mReady = (qd.size() < 2);
      acc = in_valid && mReady && !flush;
      del = mValid && out_ready;
      if (mValid && !out_ready) stallEvents++;
      if (mValid) lastData = qd[0];
      if (flush) begin
        qc.delete();
        qd.delete();
      end else begin
        if (del) begin
          void'(qc.pop_front());
          void'(qd.pop_front());
        end
        if (acc) begin
          qc.push_back(in_ctrl);
          qd.push_back(in_data);
        end
      end
      if (qd.size() > 0) lastData = qd[0];
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      int n;
      n = qd.size();
      chk("occupancy", occupancy, n);
      chk("out_valid", out_valid, n > 0);
      chk("in_ready", in_ready, n < 2);
      chk("out_ctrl", out_ctrl, (n > 0) ? qc[0] : '0);
      chk("out_data", out_data, (n > 0) ? qd[0] : lastData);
      chk("stall_count", stall_count, (stallEvents > 65535) ? 65535 : stallEvents);
      chk("sat_stall_count", sStall, (stallEvents > 15) ? 15 : stallEvents);
      chk("sat_occupancy", sOcc, n);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    // 1. Reset and bubble
    in_valid = 1'b1;
    in_ctrl  = 14'h3FFF;
    in_data  = 128'hAB;
    step();
    checkOn = 1'b1;
    step();
    chk("t1_occ", occupancy, 0);
    chk("t1_valid", out_valid, 0);
    chk("t1_ctrl", out_ctrl, 0);
    chk("t1_data", out_data, 0);
    chk("t1_ready", in_ready, 1);
    rst = 1'b1;
    step();
    chk("t1_valid_after", out_valid, 1);
    chk("t1_ctrl_after", out_ctrl, 14'h3FFF);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    // 2. Streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 14'(i * 3);
      in_data  = 128'(i);
      step();
      chk("t2_data", out_data, i);
      chk("t2_occ", occupancy, 1);
      chk("t2_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    chk("t2_drained", occupancy, 0);

    // 3. Back-pressure and skid
    doReset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 128'hA;
    in_ctrl   = 14'h00A;
    step();
    out_ready = 1'b0;
    in_data   = 128'hB;
    in_ctrl   = 14'h00B;
    step();
    in_data   = 128'hC;
    in_ctrl   = 14'h00C;
    step();
    chk("t3_occ", occupancy, 2);
    chk("t3_ready", in_ready, 0);
    chk("t3_dataA", out_data, 128'hA);
    chk("t3_stall", stall_count, 2);
    out_ready = 1'b1;
    step();
    chk("t3_dataB", out_data, 128'hB);
    step();
    chk("t3_dataC", out_data, 128'hC);
    chk("t3_ctrlC", out_ctrl, 14'h00C);
    in_valid = 1'b0;
    step();
    chk("t3_empty", out_valid, 0);
    chk("t3_stall_end", stall_count, 2);

    // 4. Flush while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h11;
    in_ctrl   = 14'h011;
    step();
    in_data   = 128'h22;
    in_ctrl   = 14'h022;
    step();
    chk("t4_full", occupancy, 2);
    flush    = 1'b1;
    in_data  = 128'hD;
    in_ctrl  = 14'h00D;
    step();
    chk("t4_occ", occupancy, 0);
    chk("t4_valid", out_valid, 0);
    chk("t4_ctrl", out_ctrl, 0);
    chk("t4_data_held", out_data, 128'h11);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("t4_ready", in_ready, 1);
    chk("t4_noD", out_valid, 0);

    // 5. Counter saturation
    doReset();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 128'h55;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("t5_sat", sStall, 15);
    chk("t5_wide", stall_count, 20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_sat_flush", sStall, 15);
    chk("t5_wide_flush", stall_count, 21);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_sat_reset", sStall, 0);

    // 6. Reset mid-operation
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 128'h66;
    step();
    in_data   = 128'h77;
    step();
    chk("t6_full", occupancy, 2);
    rst       = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t6_occ", occupancy, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_ready", in_ready, 1);
    chk("t6_ctrl", out_ctrl, 0);
    chk("t6_data", out_data, 0);
    chk("t6_stall", stall_count, 0);
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("t6_noskid", out_valid, 0);
    step();
    chk("t6_noskid2", occupancy, 0);

    // Randomized phase, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(199) != 0);
      flush     = ($urandom_range(39) == 0);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ((c / 64) % 3 == 2) ? ($urandom_range(9) < 2) : ($urandom_range(9) < 6);
      in_ctrl   = 14'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
